systolic_seq_ctrl: RTL

Sequencer for one matrix-multiply pass of the systolic datapath. It accepts the DIM rows of the A operand over a valid/ready handshake and writes them into the skewing A memory (memA). It then pulses a MAC clear and asserts the shared enable long enough for every skewed column to flow through the DIM×DIM tpumac array. It sits between the host-side loader and memA/the MAC array, and owns every enable and write-strobe they see.

---
 rtl/tpu_pkg.sv | 13 +
 rtl/seq_counter.sv | 20 ++
 rtl/systolic_seq_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared sequencer state encoding and pass-length/counter-width helpers
package tpu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_STREAM, S_DONE} seq_state_t;
  function automatic int stream_len(input int dim);
    return 3 * dim - 2;
  endfunction
  function automatic int row_cnt_w(input int dim);
    return $clog2(dim);
  endfunction
  function automatic int stream_cnt_w(input int dim);
    return $clog2(3 * dim - 1);
  endfunction
endpackage

// File: rtl/seq_counter.sv
// seq_counter: up-counter with synchronous clear, enable and terminal-count flag
module seq_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : cnt_q + W'(en_i);
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == W'(MAX);
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: loads DIM A rows into memA, clears the MACs, then streams the skewed pass
module systolic_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  row_valid,
  input  logic signed [DIM-1:0][BITS_AB-1:0]    row_data,
  output logic                                  row_ready,
  output logic                                  mem_WrEn,
  output logic [$clog2(DIM)-1:0]                mem_Arow,
  output logic signed [DIM-1:0][BITS_AB-1:0]    mem_Ain,
  output logic                                  mem_en,
  output logic                                  mac_clr,
  output logic                                  mac_en,
  output logic                                  busy,
  output logic                                  done
);
  localparam int RW = row_cnt_w(DIM);
  localparam int SW = stream_cnt_w(DIM);
  localparam int SL = stream_len(DIM);
  seq_state_t state_q;
  logic [RW-1:0] row_cnt;
  logic [SW-1:0] stream_cnt;
  logic row_last, stream_last, hs;
  assign row_ready = state_q == S_LOAD;
  assign busy      = state_q != S_IDLE;
  assign hs        = row_valid & row_ready;
  seq_counter #(.W(RW), .MAX(DIM - 1)) u_row (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q == S_IDLE), .en_i(hs),
    .cnt_o(row_cnt), .tc_o(row_last)
  );
  seq_counter #(.W(SW), .MAX(SL - 1)) u_stream (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q == S_CLEAR), .en_i(state_q == S_STREAM),
    .cnt_o(stream_cnt), .tc_o(stream_last)
  );
  // every strobe is registered so downstream sees clean, edge-aligned enables
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mem_WrEn <= 1'b0;
      mem_Arow <= '0;
      mem_Ain  <= '0;
      mem_en   <= 1'b0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_WrEn <= hs;
      mac_clr  <= 1'b0;
      done     <= 1'b0;
      if (hs) begin
        mem_Ain  <= row_data;
        mem_Arow <= row_cnt;
      end
      case (state_q)
        S_IDLE:   if (start) state_q <= S_LOAD;
        S_LOAD:   if (hs && row_last) begin
          state_q <= S_CLEAR;
          mac_clr <= 1'b1;
        end
        S_CLEAR: begin
          state_q <= S_STREAM;
          mem_en  <= 1'b1;
          mac_en  <= 1'b1;
        end
        S_STREAM: if (stream_last && stream_cnt == SW'(SL - 1)) begin
          state_q <= S_DONE;
          mem_en  <= 1'b0;
          mac_en  <= 1'b0;
          done    <= 1'b1;
        end
        S_DONE:   state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end
endmodule
